// File: rtl/ram_pkg.sv
// Shared width defaults for the scratch RAM.
package ram_pkg;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 3;

endpackage

// File: rtl/ram.sv
// Single-port synchronous scratch RAM.
// Write-first on a shared address, one-cycle registered read.
module ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_W,
    parameter int ADDR_WIDTH = RAM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            data_out <= '0;
        end else begin
            if (we) begin
                mem[addr] <= data_in;
            end
            // Same-cycle write forwards the new word to the output.
            if (re) begin
                data_out <= we ? data_in : mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: every cycle's expected data_out is
// queued when the stimulus is driven and popped after the edge.
module tb_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [7:0] mdl_mem [0:7];
    logic [7:0] mdl_dout;
    logic [7:0] exp_q [$];
    string      tag_q [$];

    ram dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .re      (re),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: data_out=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic op(input string tag, input logic r, input logic w,
                      input logic rd, input logic [2:0] a,
                      input logic [7:0] d);
        logic [7:0] e;
        string      t;
        @(negedge clk);
        rst = r;
        we = w;
        re = rd;
        addr = a;
        data_in = d;
        if (r) begin
            for (int i = 0; i < 8; i++) mdl_mem[i] = 8'h00;
            mdl_dout = 8'h00;
        end else begin
            if (rd) mdl_dout = w ? d : mdl_mem[a];
            if (w) mdl_mem[a] = d;
        end
        exp_q.push_back(mdl_dout);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, data_out, e);
    endtask

    initial begin
        mdl_dout = 8'h00;
        for (int i = 0; i < 8; i++) mdl_mem[i] = 8'h00;

        op("reset", 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            op("rst_rd", 1'b0, 1'b0, 1'b1, 3'(i), 8'h00);
            chk("rst_zero", data_out, 8'h00);
        end

        op("wr0", 1'b0, 1'b1, 1'b0, 3'd0, 8'hAA);
        op("wr1", 1'b0, 1'b1, 1'b0, 3'd1, 8'hBB);
        op("wr2", 1'b0, 1'b1, 1'b0, 3'd2, 8'hCC);
        op("rd0", 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
        chk("rd0_lit", data_out, 8'hAA);
        op("rd1", 1'b0, 1'b0, 1'b1, 3'd1, 8'h00);
        chk("rd1_lit", data_out, 8'hBB);
        op("rd2", 1'b0, 1'b0, 1'b1, 3'd2, 8'h00);
        chk("rd2_lit", data_out, 8'hCC);

        op("hold", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        op("hold2", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        chk("hold_lit", data_out, 8'hCC);

        op("rdw", 1'b0, 1'b1, 1'b1, 3'd5, 8'h5A);
        chk("rdw_lit", data_out, 8'h5A);
        op("rd_clr", 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
        op("rdw_rb", 1'b0, 1'b0, 1'b1, 3'd5, 8'h00);
        chk("rdw_rb_lit", data_out, 8'h5A);

        for (int i = 0; i < 8; i++) begin
            op("full_wr", 1'b0, 1'b1, 1'b0, 3'(i), 8'(8'h10 + i));
        end
        for (int i = 0; i < 8; i++) begin
            op("full_rd", 1'b0, 1'b0, 1'b1, 3'(i), 8'h00);
        end
        for (int i = 7; i >= 0; i--) begin
            op("full_rd_rev", 1'b0, 1'b0, 1'b1, 3'(i), 8'h00);
        end

        for (int i = 0; i < 8; i++) begin
            op("rnd", 1'b0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               8'($urandom_range(0, 255)));
        end

        op("mid_wr", 1'b0, 1'b1, 1'b0, 3'd3, 8'hFF);
        op("mid_rst", 1'b1, 1'b1, 1'b1, 3'd3, 8'h11);
        op("mid_rd", 1'b0, 1'b0, 1'b1, 3'd3, 8'h00);
        chk("mid_lit", data_out, 8'h00);
        op("mid_rd7", 1'b0, 1'b0, 1'b1, 3'd7, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
